mpu_bus_interface: RTL and testbench

// - Front end of the MPU port: turns the AVR multiplexed external-memory bus
//   (ALE / _RD / _WR, AD[7:0], AH[7:0]) into single-cycle synchronous requests.
// - Latches the low address byte and synchronises the strobes.
// - Issues one-cycle write and read requests to the register / palette decode

---
 rtl/mpu_bus_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/mpu_bus_interface.sv | 183 ++++++++++++++++++
 tb/tb_mpu_bus_interface.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_bus_pkg.sv
// Shared constants and FSM encoding for the MPU external-bus front end.
package mpu_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int RD_LATENCY_MAX = 4;
    localparam int CNT_W          = $clog2(RD_LATENCY_MAX);
    localparam int STATE_W        = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_WR_ACTIVE = 3'd2,
        ST_WR_COMMIT = 3'd3,
        ST_RD_REQ    = 3'd4,
        ST_RD_WAIT   = 3'd5,
        ST_RD_DRIVE  = 3'd6
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a group of signals that must stay cycle-aligned.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/mpu_bus_interface.sv
// AVR multiplexed-bus front end: synchronises ALE/_RD/_WR and the address/data
// pads, then issues one-cycle read/write requests to the register decode block.
module mpu_bus_interface
    import mpu_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             _mpu_rd,
    input  logic                             _mpu_wr,
    input  logic                             mpu_ale,
    input  logic [ADDR_WIDTH-DATA_WIDTH-1:0] mpu_ah,
    input  logic [DATA_WIDTH-1:0]            mpu_ad_in,
    output logic [DATA_WIDTH-1:0]            mpu_ad_out,
    output logic                             mpu_ad_oe,
    output logic [ADDR_WIDTH-1:0]            addr,
    output logic                             wr_en,
    output logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             rd_en,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             bus_error
);

    localparam int AH_W = ADDR_WIDTH - DATA_WIDTH;

    logic [1:0]            w_strb_n;
    logic                  w_rd_n;
    logic                  w_wr_n;
    logic                  w_ale;
    logic [AH_W-1:0]       w_ah;
    logic [DATA_WIDTH-1:0] w_ad;
    logic                  w_both;

    state_t                r_state;
    state_t                w_next;
    logic                  w_capture;
    logic                  w_load_cnt;
    logic                  w_dec;

    logic [DATA_WIDTH-1:0] r_addr_lo;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [DATA_WIDTH-1:0] r_ad_out;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rd_done;
    logic                  r_bus_error;

    // Strobes idle high out of reset so no phantom access is seen.
    sync_2ff #(.WIDTH(2), .RST_VAL(2'b11)) u_sync_strb (
        .clk   (clk),
        .reset (reset),
        .i_d   ({_mpu_rd, _mpu_wr}),
        .o_q   (w_strb_n)
    );

    sync_2ff #(.WIDTH(1)) u_sync_ale (
        .clk   (clk),
        .reset (reset),
        .i_d   (mpu_ale),
        .o_q   (w_ale)
    );

    sync_2ff #(.WIDTH(AH_W)) u_sync_ah (
        .clk   (clk),
        .reset (reset),
        .i_d   (mpu_ah),
        .o_q   (w_ah)
    );

    sync_2ff #(.WIDTH(DATA_WIDTH)) u_sync_ad (
        .clk   (clk),
        .reset (reset),
        .i_d   (mpu_ad_in),
        .o_q   (w_ad)
    );

    assign w_rd_n = w_strb_n[1];
    assign w_wr_n = w_strb_n[0];
    assign w_both = !w_rd_n && !w_wr_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The read latency window spans RD_REQ plus RD_WAIT; r_cnt is the cycles left.
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_load_cnt = 1'b0;
        w_dec      = 1'b0;
        if (w_both) begin
            w_next = r_state;
        end else if (w_ale) begin
            w_next = ST_ADDR;
        end else begin
            case (r_state)
                ST_IDLE, ST_ADDR: begin
                    if (!w_wr_n) begin
                        w_next = ST_WR_ACTIVE;
                    end else if (!w_rd_n && !r_rd_done) begin
                        w_next     = ST_RD_REQ;
                        w_load_cnt = 1'b1;
                    end
                end
                ST_WR_ACTIVE: begin
                    if (w_wr_n) begin
                        w_next = ST_WR_COMMIT;
                    end
                end
                ST_WR_COMMIT: begin
                    w_next = ST_IDLE;
                end
                ST_RD_REQ, ST_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        w_capture = 1'b1;
                        w_next    = w_rd_n ? ST_IDLE : ST_RD_DRIVE;
                    end else begin
                        w_dec  = 1'b1;
                        w_next = ST_RD_WAIT;
                    end
                end
                ST_RD_DRIVE: begin
                    if (w_rd_n) begin
                        w_next = ST_IDLE;
                    end
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr_lo   <= '0;
            r_wr_data   <= '0;
            r_ad_out    <= '0;
            r_cnt       <= '0;
            r_rd_done   <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            if (w_ale) begin
                r_addr_lo <= w_ad;
            end
            if (r_state == ST_WR_ACTIVE) begin
                r_wr_data <= w_ad;
            end
            if (w_capture) begin
                r_ad_out <= rd_data;
            end
            if (w_load_cnt) begin
                r_cnt <= CNT_W'(RD_LATENCY - 1);
            end else if (w_dec) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // One read request per _rd low period, even across an ALE abort.
            if (w_rd_n) begin
                r_rd_done <= 1'b0;
            end else if (w_load_cnt) begin
                r_rd_done <= 1'b1;
            end
            if (w_both) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    assign addr       = {w_ah, r_addr_lo};
    assign wr_data    = r_wr_data;
    assign wr_en      = (r_state == ST_WR_COMMIT) && !w_ale && !w_both;
    assign rd_en      = (r_state == ST_RD_REQ) && !w_ale && !w_both;
    assign mpu_ad_out = r_ad_out;
    assign mpu_ad_oe  = (r_state == ST_RD_DRIVE) && !w_rd_n && w_wr_n && !w_ale;
    assign bus_error  = r_bus_error;

endmodule

// File: tb/tb_mpu_bus_interface.sv
// Directed bench for mpu_bus_interface with RD_LATENCY = 2.
module tb_mpu_bus_interface;
    import mpu_bus_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       _mpu_rd = 1'b1;
    logic       _mpu_wr = 1'b1;
    logic       mpu_ale = 1'b0;
    logic [7:0] mpu_ah = 8'h00;
    logic [7:0] mpu_ad_in = 8'h00;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] mpu_ad_out;
    logic       mpu_ad_oe;
    logic [15:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       bus_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    int rd_cyc = -1, oe_rise_cyc = -1, oe_fall_cyc = -1, rd_rise_cyc = -1;
    logic prev_oe = 1'b0;
    logic [7:0] oe_out = 8'h00;
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [15:0] rd_addr_q[$];

    mpu_bus_interface #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        ._mpu_rd    (_mpu_rd),
        ._mpu_wr    (_mpu_wr),
        .mpu_ale    (mpu_ale),
        .mpu_ah     (mpu_ah),
        .mpu_ad_in  (mpu_ad_in),
        .mpu_ad_out (mpu_ad_out),
        .mpu_ad_oe  (mpu_ad_oe),
        .addr       (addr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(wr_data);
        end
        if (rd_en) begin
            rd_cnt++;
            rd_addr_q.push_back(addr);
            rd_cyc = cyc;
        end
        if (mpu_ad_oe) begin
            oe_cnt++;
            oe_out = mpu_ad_out;
        end
        if (mpu_ad_oe && !prev_oe) oe_rise_cyc = cyc;
        if (!mpu_ad_oe && prev_oe) oe_fall_cyc = cyc;
        prev_oe = mpu_ad_oe;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ale_phase(input logic [7:0] ah, input logic [7:0] al);
        mpu_ah = ah;
        mpu_ad_in = al;
        mpu_ale = 1'b1;
        tick(2);
        mpu_ale = 1'b0;
        tick(2);
    endtask

    task automatic write_cyc(input logic [7:0] ah, input logic [7:0] al, input logic [7:0] d, input bit use_ale);
        if (use_ale) ale_phase(ah, al);
        mpu_ad_in = d;
        _mpu_wr = 1'b0;
        tick(3);
        _mpu_wr = 1'b1;
        tick(6);
    endtask

    task automatic read_cyc(input logic [7:0] ah, input logic [7:0] al, input bit use_ale, input int low_clks);
        if (use_ale) ale_phase(ah, al);
        oe_out = 8'h00;
        _mpu_rd = 1'b0;
        tick(low_clks);
        rd_rise_cyc = cyc;
        _mpu_rd = 1'b1;
        tick(6);
    endtask

    function automatic logic [15:0] pop_a(inout logic [15:0] q[$]);
        return (q.size() > 0) ? q.pop_front() : 16'hxxxx;
    endfunction

    function automatic logic [7:0] pop_d(inout logic [7:0] q[$]);
        return (q.size() > 0) ? q.pop_front() : 8'hxx;
    endfunction

    task automatic test_reset();
        int n_wr;
        ale_phase(8'h43, 8'h21);
        mpu_ad_in = 8'h99;
        _mpu_wr = 1'b0;
        tick(4);
        checks++; if (wr_data !== 8'h99) begin errors++; $display("FAIL rst_pre_wr_data: got %h want 99", wr_data); end
        n_wr = wr_cnt;
        #2;
        reset = 1'b1;
        _mpu_wr = 1'b1;
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
        checks++; if (mpu_ad_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b want 0", mpu_ad_oe); end
        checks++; if (mpu_ad_out !== 8'h00) begin errors++; $display("FAIL rst_ad_out: got %h want 00", mpu_ad_out); end
        checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL rst_addr: got %h want 0000", addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data: got %h want 00", wr_data); end
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rst_bus_error: got %b want 0", bus_error); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want IDLE", dut.r_state); end
        tick(2);
        reset = 1'b0;
        tick(8);
        checks++; if (wr_cnt !== n_wr) begin errors++; $display("FAIL rst_no_commit: got %0d wr_en want 0", wr_cnt - n_wr); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rst_state_after: got %0d want IDLE", dut.r_state); end
    endtask

    task automatic test_write();
        int n_wr;
        wr_addr_q.delete(); wr_data_q.delete();
        n_wr = wr_cnt;
        write_cyc(8'h12, 8'h34, 8'hAD, 1'b1);
        checks++; if (wr_cnt - n_wr !== 1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_cnt - n_wr); end
        checks++; if (pop_a(wr_addr_q) !== 16'h1234) begin errors++; $display("FAIL wr_addr: wrong address want 1234"); end
        checks++; if (pop_d(wr_data_q) !== 8'hAD) begin errors++; $display("FAIL wr_data: wrong data want AD"); end
    endtask

    task automatic test_read();
        int n_rd, n_oe;
        rd_addr_q.delete();
        n_rd = rd_cnt; n_oe = oe_cnt;
        rd_data = 8'h5A;
        read_cyc(8'h10, 8'h00, 1'b1, 8);
        checks++; if (rd_cnt - n_rd !== 1) begin errors++; $display("FAIL rd_count: got %0d want 1", rd_cnt - n_rd); end
        checks++; if (pop_a(rd_addr_q) !== 16'h1000) begin errors++; $display("FAIL rd_addr: wrong address want 1000"); end
        checks++; if (oe_rise_cyc - rd_cyc !== 2) begin errors++; $display("FAIL rd_oe_latency: got %0d want 2", oe_rise_cyc - rd_cyc); end
        checks++; if (oe_out !== 8'h5A) begin errors++; $display("FAIL rd_out: got %h want 5A", oe_out); end
        checks++; if (oe_fall_cyc !== rd_rise_cyc + 2) begin errors++; $display("FAIL rd_oe_fall: got %0d want %0d", oe_fall_cyc, rd_rise_cyc + 2); end
        checks++; if (oe_cnt - n_oe !== 5) begin errors++; $display("FAIL rd_oe_width: got %0d want 5", oe_cnt - n_oe); end
    endtask

    task automatic test_back_to_back();
        int n_wr;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        n_wr = wr_cnt;
        write_cyc(8'h00, 8'h00, 8'hAD, 1'b1);
        write_cyc(8'h00, 8'h01, 8'hDE, 1'b1);
        checks++; if (wr_cnt - n_wr !== 2) begin errors++; $display("FAIL b2b_wr_count: got %0d want 2", wr_cnt - n_wr); end
        checks++; if (pop_a(wr_addr_q) !== 16'h0000) begin errors++; $display("FAIL b2b_wr_addr0: wrong address want 0000"); end
        checks++; if (pop_d(wr_data_q) !== 8'hAD) begin errors++; $display("FAIL b2b_wr_data0: wrong data want AD"); end
        checks++; if (pop_a(wr_addr_q) !== 16'h0001) begin errors++; $display("FAIL b2b_wr_addr1: wrong address want 0001"); end
        checks++; if (pop_d(wr_data_q) !== 8'hDE) begin errors++; $display("FAIL b2b_wr_data1: wrong data want DE"); end
        rd_data = 8'hAD;
        read_cyc(8'h00, 8'h00, 1'b1, 6);
        checks++; if (pop_a(rd_addr_q) !== 16'h0000) begin errors++; $display("FAIL b2b_rd_addr0: wrong address want 0000"); end
        checks++; if (oe_out !== 8'hAD) begin errors++; $display("FAIL b2b_rd_out0: got %h want AD", oe_out); end
        rd_data = 8'hDE;
        read_cyc(8'h00, 8'h01, 1'b1, 6);
        checks++; if (pop_a(rd_addr_q) !== 16'h0001) begin errors++; $display("FAIL b2b_rd_addr1: wrong address want 0001"); end
        checks++; if (oe_out !== 8'hDE) begin errors++; $display("FAIL b2b_rd_out1: got %h want DE", oe_out); end
        rd_data = 8'h3C;
        read_cyc(8'h00, 8'hFF, 1'b0, 6);
        checks++; if (pop_a(rd_addr_q) !== 16'h0001) begin errors++; $display("FAIL b2b_reuse_addr: wrong address want 0001"); end
        checks++; if (oe_out !== 8'h3C) begin errors++; $display("FAIL b2b_reuse_out: got %h want 3C", oe_out); end
    endtask

    task automatic test_abort();
        int n_rd, n_oe;
        rd_addr_q.delete();
        n_rd = rd_cnt; n_oe = oe_cnt;
        rd_data = 8'h77;
        ale_phase(8'h20, 8'h00);
        _mpu_rd = 1'b0;
        tick(2);
        mpu_ah = 8'h20;
        mpu_ad_in = 8'h55;
        mpu_ale = 1'b1;
        tick(2);
        mpu_ale = 1'b0;
        _mpu_rd = 1'b1;
        tick(6);
        checks++; if (rd_cnt - n_rd !== 1) begin errors++; $display("FAIL abort_rd_count: got %0d want 1", rd_cnt - n_rd); end
        checks++; if (pop_a(rd_addr_q) !== 16'h2000) begin errors++; $display("FAIL abort_rd_addr: wrong address want 2000"); end
        checks++; if (oe_cnt !== n_oe) begin errors++; $display("FAIL abort_no_oe: got %0d oe cycles want 0", oe_cnt - n_oe); end
        read_cyc(8'h00, 8'h00, 1'b0, 6);
        checks++; if (pop_a(rd_addr_q) !== 16'h2055) begin errors++; $display("FAIL abort_next_addr: wrong address want 2055"); end
        checks++; if (oe_out !== 8'h77) begin errors++; $display("FAIL abort_next_out: got %h want 77", oe_out); end
        checks++; if (oe_cnt - n_oe !== 3) begin errors++; $display("FAIL abort_next_oe: got %0d want 3", oe_cnt - n_oe); end
    endtask

    task automatic test_error();
        int n_rd, n_wr, n_oe;
        n_rd = rd_cnt; n_wr = wr_cnt; n_oe = oe_cnt;
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL err_pre: got %b want 0", bus_error); end
        _mpu_rd = 1'b0;
        _mpu_wr = 1'b0;
        tick(4);
        checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", bus_error); end
        _mpu_rd = 1'b1;
        _mpu_wr = 1'b1;
        tick(6);
        checks++; if (rd_cnt !== n_rd) begin errors++; $display("FAIL err_no_rd: got %0d want 0", rd_cnt - n_rd); end
        checks++; if (wr_cnt !== n_wr) begin errors++; $display("FAIL err_no_wr: got %0d want 0", wr_cnt - n_wr); end
        checks++; if (oe_cnt !== n_oe) begin errors++; $display("FAIL err_no_oe: got %0d want 0", oe_cnt - n_oe); end
        write_cyc(8'h12, 8'h34, 8'h11, 1'b1);
        checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus_error); end
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus_error); end
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(3);
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_abort();
        test_error();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
